// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder
// Packs a stream of (feature, weight) operand pairs into LANES-wide vectors
// for the convolution MAC. It drives the per-lane multiply enables and the
// accumulator controls: local_reset before each output, load with its final
// vector.
// Build option: FEEDER_ZERO_PAD_EN -- clear the pack registers on every entry
// to FILL, so lanes left unwritten in a partial vector read 0.
module mac_operand_feeder #(
    parameter int LANES = 64,
    parameter int DW    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [15:0]         kernel_len,
    input  logic [15:0]         num_outputs,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_if,
    input  logic [DW-1:0]       in_kw,
    output logic [LANES*DW-1:0] IF_map_Out,
    output logic [LANES*DW-1:0] KW_map_Out,
    output logic [LANES-1:0]    MUL_EN,
    output logic                load,
    output logic                local_reset,
    output logic                busy,
    output logic                done
);

    localparam int KIW = $clog2(LANES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FILL,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [15:0]          kl_q;       // latched kernel_len
    logic [15:0]          outs_q;     // outputs not yet started
    logic [15:0]          rem_q;      // products still to pack for this output
    logic [KIW-1:0]       k_q;        // next lane to write
    logic [LANES-1:0]     mask_q;     // lanes written in the current vector
    logic [LANES*DW-1:0]  if_pack_q, kw_pack_q;
    logic [LANES*DW-1:0]  if_pack_d, kw_pack_d;
    logic                 hs, fill_last, start_ok;

    assign start_ok  = start && (kernel_len != 16'd0) && (num_outputs != 16'd0);
    assign hs        = (state_q == S_FILL) && in_valid;
    // rem_q is never 0 while in FILL, so rem_q==1 marks the output's last product.
    assign fill_last = hs && ((k_q == KIW'(LANES - 1)) || (rem_q == 16'd1));

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and a latch can never be inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = start_ok ? S_CLEAR : S_DONE;
            S_CLEAR: state_d = S_FILL;
            S_FILL:  if (fill_last) state_d = S_ISSUE;
            S_ISSUE: begin
                if (rem_q != 16'd0)       state_d = S_FILL;
                else if (outs_q != 16'd0) state_d = S_CLEAR;
                else                      state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: strobes come straight from the state, MUL_EN is gated to ISSUE.
    always_comb begin
        in_ready    = (state_q == S_FILL);
        local_reset = (state_q == S_CLEAR);
        MUL_EN      = (state_q == S_ISSUE) ? mask_q : '0;
        load        = (state_q == S_ISSUE) && (rem_q == 16'd0);
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
    end

    // Pack registers with the accepted pair written into lane k.
    always_comb begin
        if_pack_d = if_pack_q;
        kw_pack_d = kw_pack_q;
        if (hs) begin
            if_pack_d[k_q*DW +: DW] = in_if;
            kw_pack_d[k_q*DW +: DW] = in_kw;
        end
    end

    // Datapath: job parameters, counters, lane packing and the held output vectors.
    // NOTE: the pack and vector registers are a flop array rather than a RAM,
    // so they can take the async reset and present all-zero vectors after it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            kl_q       <= '0;
            outs_q     <= '0;
            rem_q      <= '0;
            k_q        <= '0;
            mask_q     <= '0;
            if_pack_q  <= '0;
            kw_pack_q  <= '0;
            IF_map_Out <= '0;
            KW_map_Out <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_ok) begin
                        kl_q   <= kernel_len;
                        outs_q <= num_outputs;
                    end
                end
                S_CLEAR: begin
                    rem_q  <= kl_q;
                    k_q    <= '0;
                    outs_q <= outs_q - 16'd1;
`ifdef FEEDER_ZERO_PAD_EN
                    if_pack_q <= '0;
                    kw_pack_q <= '0;
`endif
                end
                S_FILL: begin
                    if (hs) begin
                        if_pack_q   <= if_pack_d;
                        kw_pack_q   <= kw_pack_d;
                        mask_q[k_q] <= 1'b1;
                        k_q         <= k_q + KIW'(1);
                        rem_q       <= rem_q - 16'd1;
                        // The completing pair goes straight into the issued vector.
                        if (fill_last) begin
                            IF_map_Out <= if_pack_d;
                            KW_map_Out <= kw_pack_d;
                        end
                    end
                end
                S_ISSUE: begin
                    mask_q <= '0;
                    k_q    <= '0;
`ifdef FEEDER_ZERO_PAD_EN
                    if_pack_q <= '0;
                    kw_pack_q <= '0;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder
// Scoreboard bench for mac_operand_feeder. Each job's expected local_reset,
// ISSUE and done events are computed from the operand list with plain
// arithmetic and queued. A negedge monitor pops and compares an entry each
// time the DUT shows one of these events.
module tb_mac_operand_feeder;

    localparam int LANES = 64;
    localparam int DW    = 16;
`ifdef FEEDER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                start = 1'b0;
    logic [15:0]         kernel_len = '0;
    logic [15:0]         num_outputs = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DW-1:0]       in_if = '0;
    logic [DW-1:0]       in_kw = '0;
    logic [LANES*DW-1:0] IF_map_Out;
    logic [LANES*DW-1:0] KW_map_Out;
    logic [LANES-1:0]    MUL_EN;
    logic                load, local_reset, busy, done;

    mac_operand_feeder #(.LANES(LANES), .DW(DW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .kernel_len(kernel_len), .num_outputs(num_outputs),
        .in_valid(in_valid), .in_ready(in_ready), .in_if(in_if), .in_kw(in_kw),
        .IF_map_Out(IF_map_Out), .KW_map_Out(KW_map_Out), .MUL_EN(MUL_EN),
        .load(load), .local_reset(local_reset), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef enum int {EV_LR, EV_ISSUE, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t            kind;
        logic [LANES*DW-1:0] ifv;
        logic [LANES*DW-1:0] kwv;
        logic [LANES-1:0]    mask;
        bit                  load;
    } ev_t;

    ev_t           exp_q[$];
    logic [DW-1:0] m_if[LANES];   // model of the lane contents the feeder holds
    logic [DW-1:0] m_kw[LANES];
    logic [DW-1:0] pif[$];
    logic [DW-1:0] pkw[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            prev_load = 1'b0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    endtask

    task automatic expect_event(input ev_kind_t k);
        ev_t e;
        int  bad;
        int  bl;
        check(exp_q.size() != 0, "event_expected", 64'(k), 64'hdead);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check(e.kind == k, "event_kind", 64'(k), 64'(e.kind));
        if (k == EV_ISSUE && e.kind == EV_ISSUE) begin
            check(MUL_EN == e.mask, "issue_mul_en", MUL_EN, e.mask);
            check(load == e.load, "issue_load", 64'(load), 64'(e.load));
            check(!in_ready, "issue_in_ready", 64'(in_ready), 64'd0);
            bad = -1;
            for (int j = 0; j < LANES; j++) begin
                if (bad < 0 && (IF_map_Out[j*DW +: DW] !== e.ifv[j*DW +: DW] ||
                                KW_map_Out[j*DW +: DW] !== e.kwv[j*DW +: DW]))
                    bad = j;
            end
            bl = (bad < 0) ? 0 : bad;
            check(bad < 0, "issue_lanes",
                  {16'(bl), 16'd0, IF_map_Out[bl*DW +: DW], KW_map_Out[bl*DW +: DW]},
                  {16'(bl), 16'd0, e.ifv[bl*DW +: DW], e.kwv[bl*DW +: DW]});
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin
        if (!reset) begin
            prev_load = 1'b0;
        end else begin
            if (prev_load)
                check(local_reset || done, "after_load_next", {62'd0, local_reset, done}, 64'd2);
            if (load) begin
                check(!local_reset, "load_lr_exclusive", 64'(local_reset), 64'd0);
                check(MUL_EN != '0, "load_only_in_issue", MUL_EN, 64'hffff_ffff_ffff_ffff);
            end
            if (local_reset) expect_event(EV_LR);
            if (MUL_EN != '0) expect_event(EV_ISSUE);
            if (done)        expect_event(EV_DONE);
            prev_load = load;
        end
    end

    task automatic model_reset();
        for (int j = 0; j < LANES; j++) begin
            m_if[j] = '0;
            m_kw[j] = '0;
        end
    endtask

    // Reference model: each output of L products is split into vectors of up to
    // LANES pairs; unwritten lanes keep old contents unless zero-padding is built in.
    task automatic model_job(input int len, input int nout);
        ev_t e;
        int  idx = 0;
        int  rem;
        int  lanes;
        if (len != 0 && nout != 0) begin
            for (int o = 0; o < nout; o++) begin
                e = '{kind: EV_LR, ifv: '0, kwv: '0, mask: '0, load: 1'b0};
                exp_q.push_back(e);
                rem = len;
                while (rem > 0) begin
                    lanes = (rem > LANES) ? LANES : rem;
                    if (ZERO_PAD) model_reset();
                    for (int j = 0; j < lanes; j++) begin
                        m_if[j] = pif[idx];
                        m_kw[j] = pkw[idx];
                        idx++;
                    end
                    rem -= lanes;
                    e.kind = EV_ISSUE;
                    for (int j = 0; j < LANES; j++) begin
                        e.ifv[j*DW +: DW] = m_if[j];
                        e.kwv[j*DW +: DW] = m_kw[j];
                    end
                    e.mask = {LANES{1'b1}} >> (LANES - lanes);
                    e.load = (rem == 0);
                    exp_q.push_back(e);
                end
            end
        end
        e = '{kind: EV_DONE, ifv: '0, kwv: '0, mask: '0, load: 1'b0};
        exp_q.push_back(e);
    endtask

    // Drive one pair; optional idle cycles first; poke pulses a stray start.
    task automatic send(input logic [DW-1:0] fv, input logic [DW-1:0] wv, input int gap_pct, input bit poke);
        int cnt = 0;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_if    = fv;
        in_kw    = wv;
        if (poke) begin
            start       = 1'b1;
            kernel_len  = 16'd3;
            num_outputs = 16'd9;
        end
        while (!in_ready && cnt < 300) begin
            @(posedge clock); #1;
            start = 1'b0;
            cnt++;
        end
        check(in_ready, "ready_timeout", 64'(in_ready), 64'd1);
        if (!in_ready) finish_run();
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // mode 0: random pairs, 1: (k+1, 2) ramp, 2: first LANES pairs 0xFFFF then random
    task automatic run_job(input int len, input int nout, input int mode, input int gap_pct, input bit poke);
        int total;
        int cnt = 0;
        pif.delete();
        pkw.delete();
        total = len * nout;
        for (int i = 0; i < total; i++) begin
            if (mode == 1) begin
                pif.push_back(DW'(i + 1));
                pkw.push_back(DW'(2));
            end else if (mode == 2 && i < LANES) begin
                pif.push_back(16'hFFFF);
                pkw.push_back(16'hFFFF);
            end else begin
                pif.push_back(DW'($urandom));
                pkw.push_back(DW'($urandom));
            end
        end
        model_job(len, nout);
        start       = 1'b1;
        kernel_len  = 16'(len);
        num_outputs = 16'(nout);
        @(posedge clock); #1;
        start = 1'b0;
        if (total == 0) begin
            check(done, "zero_job_done", 64'(done), 64'd1);
            check(!local_reset, "zero_job_no_lr", 64'(local_reset), 64'd0);
            check(!in_ready, "zero_job_no_ready", 64'(in_ready), 64'd0);
        end else begin
            check(local_reset, "start_local_reset", 64'(local_reset), 64'd1);
            @(posedge clock); #1;
            check(in_ready, "start_in_ready", 64'(in_ready), 64'd1);
        end
        for (int i = 0; i < total; i++)
            send(pif[i], pkw[i], gap_pct, poke && (i == 10));
        in_valid = 1'b0;
        while (!done && cnt < 300) begin
            @(posedge clock); #1;
            cnt++;
        end
        check(done, "done_seen", 64'(done), 64'd1);
        check(busy, "busy_during_done", 64'(busy), 64'd1);
        @(posedge clock); #1;
        check(!busy, "busy_after_done", 64'(busy), 64'd0);
        check(exp_q.size() == 0, "scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check(!in_ready, {tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check(MUL_EN == '0, {tag, "_mul_en"}, MUL_EN, 64'd0);
        check(!load, {tag, "_load"}, 64'(load), 64'd0);
        check(!local_reset, {tag, "_local_reset"}, 64'(local_reset), 64'd0);
        check(!busy, {tag, "_busy"}, 64'(busy), 64'd0);
        check(!done, {tag, "_done"}, 64'(done), 64'd0);
        check(IF_map_Out == '0, {tag, "_if_vec_nonzero"}, 64'(|IF_map_Out), 64'd0);
        check(KW_map_Out == '0, {tag, "_kw_vec_nonzero"}, 64'(|KW_map_Out), 64'd0);
    endtask

    initial begin
        ev_t e;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b1;
        @(posedge clock); #1;

        // Single full vector, ramp data.
        run_job(64, 1, 1, 0, 1'b0);
        // Two outputs of 100 products, back to back and then with gaps.
        run_job(100, 2, 0, 0, 1'b0);
        run_job(100, 2, 0, 40, 1'b0);
        // Degenerate jobs finish with done only.
        run_job(0, 3, 0, 0, 1'b0);
        run_job(5, 0, 0, 0, 1'b0);
        // Stray start during a running job must be ignored.
        run_job(130, 2, 0, 20, 1'b1);

        // Reset in the middle of a 64-product output.
        e = '{kind: EV_LR, ifv: '0, kwv: '0, mask: '0, load: 1'b0};
        exp_q.push_back(e);
        start = 1'b1; kernel_len = 16'd64; num_outputs = 16'd1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 30; i++) send(DW'($urandom), DW'($urandom), 0, 1'b0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("midjob_reset");
        check(exp_q.size() == 0, "midjob_queue", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        model_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        run_job(5, 1, 0, 0, 1'b0);

        // Partial vector after a full 0xFFFF vector: padding behaviour.
        run_job(100, 1, 2, 0, 1'b0);
        check(IF_map_Out[63*DW +: DW] == (ZERO_PAD ? 16'h0000 : 16'hFFFF), "pad_lane63_if",
              64'(IF_map_Out[63*DW +: DW]), ZERO_PAD ? 64'h0 : 64'hFFFF);
        check(KW_map_Out[36*DW +: DW] == (ZERO_PAD ? 16'h0000 : 16'hFFFF), "pad_lane36_kw",
              64'(KW_map_Out[36*DW +: DW]), ZERO_PAD ? 64'h0 : 64'hFFFF);

        // A few random jobs.
        for (int r = 0; r < 4; r++)
            run_job($urandom_range(200, 1), $urandom_range(3, 1), 0, $urandom_range(50, 0), 1'b0);

        finish_run();
    end

endmodule
